// File: rtl/mem_access_unit_if.sv
// Data-memory port of the MEM stage: req/gnt/rvalid handshake with address,
// write data, byte enables and read data.
interface mem_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I MEM stage: performs the EX/MEM load/store over the data-memory port and
// registers the result for MEM/WB; non-memory ops pass through in one cycle.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [31:0]       alu_out_in,
    input  logic [31:0]       store_data_in,
    input  logic [2:0]        funct3_in,
    input  logic [4:0]        instruction_rd_in,
    input  logic              register_write_enable_in,
    input  logic              mem_request_type_in,
    input  logic              mem_request_write_in,
    input  logic [2:0]        wb_sel_in,
    output logic              stall,
    mem_access_unit_if.master dmem,
    output logic              valid_out,
    output logic [31:0]       alu_out,
    output logic [31:0]       load_data_out,
    output logic [4:0]        instruction_rd_out,
    output logic              register_write_enable_out,
    output logic [2:0]        wb_sel_out,
    output logic              misaligned_out,
    output logic              bus_timeout_out
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic        rwe_q;
    logic [2:0]  wb_sel_q;

    logic        valid_q;
    logic [31:0] alu_out_q;
    logic [31:0] load_q;
    logic [4:0]  rd_out_q;
    logic        rwe_out_q;
    logic [2:0]  wb_sel_out_q;
    logic        mis_q;
    logic        to_q;

    logic        misaligned_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] lane_d;
    logic [31:0] load_d;
    logic        done_d;
    logic        abort_d;

    // Alignment check, byte enables and lane replication for the incoming op.
    always_comb begin
        misaligned_d = 1'b0;
        be_d         = 4'b1111;
        wdata_d      = store_data_in;
        case (funct3_in[1:0])
            2'b00: begin
                if (mem_request_write_in) be_d = 4'b0001 << alu_out_in[1:0];
                wdata_d = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                misaligned_d = alu_out_in[0];
                if (mem_request_write_in) be_d = alu_out_in[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{store_data_in[15:0]}};
            end
            2'b10: misaligned_d = (alu_out_in[1:0] != 2'b00);
            default: ;
        endcase
    end

    always_comb begin
        lane_d = dmem.dmem_rdata >> {addr_q[1:0], 3'b000};
        load_d = dmem.dmem_rdata;
        case (funct3_q)
            3'b000:  load_d = {{24{lane_d[7]}}, lane_d[7:0]};
            3'b001:  load_d = {{16{lane_d[15]}}, lane_d[15:0]};
            3'b100:  load_d = {24'd0, lane_d[7:0]};
            3'b101:  load_d = {16'd0, lane_d[15:0]};
            default: load_d = dmem.dmem_rdata;
        endcase
    end

    // A response arriving on the final allowed cycle still completes normally.
    always_comb begin
        done_d  = ((state_q == REQ) && dmem.dmem_gnt && dmem.dmem_rvalid)
               || ((state_q == RESP) && dmem.dmem_rvalid);
        abort_d = !done_d && (state_q != IDLE) && (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            rd_q         <= '0;
            rwe_q        <= 1'b0;
            wb_sel_q     <= '0;
            valid_q      <= 1'b0;
            alu_out_q    <= '0;
            load_q       <= '0;
            rd_out_q     <= '0;
            rwe_out_q    <= 1'b0;
            wb_sel_out_q <= '0;
            mis_q        <= 1'b0;
            to_q         <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_in) begin
                        if (mem_request_type_in && !misaligned_d) begin
                            state_q  <= REQ;
                            cnt_q    <= '0;
                            addr_q   <= alu_out_in;
                            wdata_q  <= wdata_d;
                            be_q     <= be_d;
                            we_q     <= mem_request_write_in;
                            funct3_q <= funct3_in;
                            rd_q     <= instruction_rd_in;
                            rwe_q    <= register_write_enable_in;
                            wb_sel_q <= wb_sel_in;
                        end else begin
                            // Pass-through op, or a misaligned access that never reaches the bus.
                            valid_q      <= 1'b1;
                            alu_out_q    <= alu_out_in;
                            load_q       <= '0;
                            rd_out_q     <= instruction_rd_in;
                            wb_sel_out_q <= wb_sel_in;
                            rwe_out_q    <= register_write_enable_in & ~mem_request_type_in;
                            mis_q        <= mem_request_type_in;
                        end
                    end
                end
                default: begin
                    if (done_d || abort_d) begin
                        state_q      <= IDLE;
                        valid_q      <= 1'b1;
                        alu_out_q    <= addr_q;
                        load_q       <= (done_d && !we_q) ? load_d : '0;
                        rd_out_q     <= rd_q;
                        wb_sel_out_q <= wb_sel_q;
                        rwe_out_q    <= rwe_q & done_d;
                        to_q         <= abort_d;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if ((state_q == REQ) && dmem.dmem_gnt) state_q <= RESP;
                    end
                end
            endcase
        end
    end

    assign stall                     = (state_q != IDLE);
    assign dmem.dmem_req             = (state_q == REQ);
    assign dmem.dmem_we              = we_q;
    assign dmem.dmem_addr            = {addr_q[31:2], 2'b00};
    assign dmem.dmem_wdata           = wdata_q;
    assign dmem.dmem_be              = be_q;
    assign valid_out                 = valid_q;
    assign alu_out                   = alu_out_q;
    assign load_data_out             = load_q;
    assign instruction_rd_out        = rd_out_q;
    assign register_write_enable_out = rwe_out_q;
    assign wb_sel_out                = wb_sel_out_q;
    assign misaligned_out            = mis_q;
    assign bus_timeout_out           = to_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level model predicts stall,
// bus requests and MEM/WB results; one negedge process compares every cycle.
module tb_mem_access_unit;
    localparam int unsigned T = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] alu_out_in;
    logic [31:0] store_data_in;
    logic [2:0]  funct3_in;
    logic [4:0]  instruction_rd_in;
    logic        register_write_enable_in;
    logic        mem_request_type_in;
    logic        mem_request_write_in;
    logic [2:0]  wb_sel_in;
    logic        stall;
    logic        valid_out;
    logic [31:0] alu_out;
    logic [31:0] load_data_out;
    logic [4:0]  instruction_rd_out;
    logic        register_write_enable_out;
    logic [2:0]  wb_sel_out;
    logic        misaligned_out;
    logic        bus_timeout_out;

    mem_access_unit_if bus();

    mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .valid_in                  (valid_in),
        .alu_out_in                (alu_out_in),
        .store_data_in             (store_data_in),
        .funct3_in                 (funct3_in),
        .instruction_rd_in         (instruction_rd_in),
        .register_write_enable_in  (register_write_enable_in),
        .mem_request_type_in       (mem_request_type_in),
        .mem_request_write_in      (mem_request_write_in),
        .wb_sel_in                 (wb_sel_in),
        .stall                     (stall),
        .dmem                      (bus),
        .valid_out                 (valid_out),
        .alu_out                   (alu_out),
        .load_data_out             (load_data_out),
        .instruction_rd_out        (instruction_rd_out),
        .register_write_enable_out (register_write_enable_out),
        .wb_sel_out                (wb_sel_out),
        .misaligned_out            (misaligned_out),
        .bus_timeout_out           (bus_timeout_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        chk_en = 1'b0;
    logic        exp_stall, exp_valid, exp_req;
    logic [31:0] exp_alu, exp_load, exp_addr, exp_wdata;
    logic [4:0]  exp_rd;
    logic        exp_rwe, exp_mis, exp_to, exp_we;
    logic [2:0]  exp_wbsel;
    logic [3:0]  exp_be;
    logic [3:0]  seen_be;
    logic [31:0] seen_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned acc_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
        int unsigned sz = acc_size(f3);
        logic [31:0] mask;
        logic [31:0] v;
        if (sz == 4) return word;
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v = (word >> (8 * (addr % 4))) & mask;
        if (!f3[2] && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 32'(stall), 32'(exp_stall));
            chk("valid_out", 32'(valid_out), 32'(exp_valid));
            chk("dmem_req", 32'(bus.dmem_req), 32'(exp_req));
            if (exp_req) begin
                chk("dmem_addr", bus.dmem_addr, exp_addr);
                chk("dmem_be", 32'(bus.dmem_be), 32'(exp_be));
                chk("dmem_we", 32'(bus.dmem_we), 32'(exp_we));
                if (exp_we) chk("dmem_wdata", bus.dmem_wdata, exp_wdata);
            end
            if (exp_valid) begin
                chk("alu_out", alu_out, exp_alu);
                chk("load_data_out", load_data_out, exp_load);
                chk("rd_out", 32'(instruction_rd_out), 32'(exp_rd));
                chk("rwe_out", 32'(register_write_enable_out), 32'(exp_rwe));
                chk("wb_sel_out", 32'(wb_sel_out), 32'(exp_wbsel));
                chk("misaligned_out", 32'(misaligned_out), 32'(exp_mis));
                chk("bus_timeout_out", 32'(bus_timeout_out), 32'(exp_to));
            end else begin
                chk("misaligned_idle", 32'(misaligned_out), 32'd0);
                chk("timeout_idle", 32'(bus_timeout_out), 32'd0);
            end
        end
    end

    task automatic set_junk();
        valid_in                 = 1'b0;
        alu_out_in               = 32'hA5A5_A5A5;
        store_data_in            = 32'h5A5A_5A5A;
        funct3_in                = 3'b111;
        instruction_rd_in        = 5'd31;
        register_write_enable_in = 1'b1;
        mem_request_type_in      = 1'b1;
        mem_request_write_in     = 1'b1;
        wb_sel_in                = 3'b111;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_valid"}, 32'(valid_out), 32'd0);
        chk({tag, "_alu"}, alu_out, 32'd0);
        chk({tag, "_load"}, load_data_out, 32'd0);
        chk({tag, "_rd"}, 32'(instruction_rd_out), 32'd0);
        chk({tag, "_rwe"}, 32'(register_write_enable_out), 32'd0);
        chk({tag, "_wbsel"}, 32'(wb_sel_out), 32'd0);
        chk({tag, "_mis"}, 32'(misaligned_out), 32'd0);
        chk({tag, "_to"}, 32'(bus_timeout_out), 32'd0);
        chk({tag, "_req"}, 32'(bus.dmem_req), 32'd0);
        chk({tag, "_addr"}, bus.dmem_addr, 32'd0);
        chk({tag, "_be"}, 32'(bus.dmem_be), 32'd0);
    endtask

    // gnt_dly: REQ cycles before the one carrying gnt (-1 = never granted).
    // rsp_dly: RESP cycles until rvalid (0 = rvalid together with gnt).
    task automatic run_op(input logic mem, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                          input logic rwe, input logic [2:0] wbsel, input int gnt_dly,
                          input int rsp_dly, input logic [31:0] rdata);
        int unsigned sz;
        logic mis;
        logic timed_out;
        int busy;
        int done_at;
        sz      = acc_size(f3);
        mis     = mem && ((addr % sz) != 0);
        done_at = (gnt_dly < 0) ? -1 : gnt_dly + 1 + rsp_dly;
        if (!mem || mis) begin
            busy = 0; timed_out = 1'b0;
        end else if (done_at >= 1 && done_at <= int'(T)) begin
            busy = done_at; timed_out = 1'b0;
        end else begin
            busy = int'(T); timed_out = 1'b1;
        end
        exp_alu   = addr;
        exp_rd    = rd;
        exp_wbsel = wbsel;
        exp_rwe   = rwe && !mis && !timed_out;
        exp_mis   = mis;
        exp_to    = timed_out;
        exp_load  = (mem && !wr && !mis && !timed_out) ? model_load(f3, addr, rdata) : 32'd0;
        exp_addr  = addr & ~32'd3;
        exp_we    = wr;
        exp_be    = wr ? 4'(((32'd1 << sz) - 32'd1) << addr[1:0]) : 4'hF;
        case (sz)
            1:       exp_wdata = {24'd0, sd[7:0]} * 32'h0101_0101;
            2:       exp_wdata = {16'd0, sd[15:0]} * 32'h0001_0001;
            default: exp_wdata = sd;
        endcase

        step();
        chk_en                   = 1'b1;
        valid_in                 = 1'b1;
        alu_out_in               = addr;
        store_data_in            = sd;
        funct3_in                = f3;
        instruction_rd_in        = rd;
        register_write_enable_in = rwe;
        mem_request_type_in      = mem;
        mem_request_write_in     = wr;
        wb_sel_in                = wbsel;
        exp_stall = 1'b0; exp_valid = 1'b0; exp_req = 1'b0;
        for (int i = 1; i <= busy; i++) begin
            step();
            set_junk();
            exp_stall        = 1'b1;
            exp_req          = (gnt_dly < 0) || (i <= gnt_dly + 1);
            bus.dmem_gnt     = (i == gnt_dly + 1);
            bus.dmem_rvalid  = (i == done_at);
            bus.dmem_rdata   = (i == done_at) ? rdata : 32'hDEAD_BEEF;
            if (i == 1) begin
                seen_be    = bus.dmem_be;
                seen_wdata = bus.dmem_wdata;
            end
        end
        step();
        set_junk();
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = 32'h0BAD_F00D;
        exp_stall = 1'b0; exp_req = 1'b0; exp_valid = 1'b1;
        step();
        exp_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_junk();
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'd0;
        exp_stall = 1'b0; exp_valid = 1'b0; exp_req = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;

        // ADD
        run_op(1'b0, 1'b0, 3'b000, 32'h10, 32'h0, 5'd5, 1'b1, 3'd1, 0, 0, 32'h0);
        chk("ADD_alu_pin", alu_out, 32'h10);
        chk("ADD_rd_pin", 32'(instruction_rd_out), 32'd5);
        // LB, gnt one cycle late, rvalid two cycles after
        run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd6, 1'b1, 3'd2, 1, 2, 32'h80FF_FF00);
        chk("LB_pin", load_data_out, 32'hFFFF_FF80);
        // SH, gnt and rvalid together
        run_op(1'b1, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd0, 1'b0, 3'd0, 0, 0, 32'h0);
        chk("SH_be_pin", 32'(seen_be), 32'h0000_000C);
        chk("SH_wdata_pin", seen_wdata, 32'hABCD_ABCD);
        // LW misaligned
        run_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd8, 1'b1, 3'd2, 0, 0, 32'h0);
        chk("LW_mis_rwe_pin", 32'(register_write_enable_out), 32'd0);
        // LBU, LH, LW, LHU
        run_op(1'b1, 1'b0, 3'b100, 32'h101, 32'h0, 5'd9, 1'b1, 3'd2, 2, 1, 32'h1234_80FF);
        chk("LBU_pin", load_data_out, 32'h0000_0080);
        run_op(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 5'd10, 1'b1, 3'd2, 0, 3, 32'h8001_0000);
        chk("LH_pin", load_data_out, 32'hFFFF_8001);
        run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd11, 1'b1, 3'd2, 0, 1, 32'hCAFE_BABE);
        run_op(1'b1, 1'b0, 3'b101, 32'h2, 32'h0, 5'd12, 1'b1, 3'd3, 0, 1, 32'h9ABC_1234);
        chk("LHU_pin", load_data_out, 32'h0000_9ABC);
        // SB, SW, misaligned SH and LH
        run_op(1'b1, 1'b1, 3'b000, 32'h301, 32'h0000_0055, 5'd0, 1'b0, 3'd0, 1, 0, 32'h0);
        chk("SB_be_pin", 32'(seen_be), 32'h0000_0002);
        chk("SB_wdata_pin", seen_wdata, 32'h5555_5555);
        run_op(1'b1, 1'b1, 3'b010, 32'h400, 32'h1357_9BDF, 5'd0, 1'b0, 3'd0, 0, 1, 32'h0);
        run_op(1'b1, 1'b1, 3'b001, 32'h203, 32'hFFFF_0000, 5'd0, 1'b0, 3'd0, 0, 0, 32'h0);
        run_op(1'b1, 1'b0, 3'b001, 32'h1, 32'h0, 5'd13, 1'b1, 3'd2, 0, 0, 32'h0);
        // Back-to-back ALU ops
        run_op(1'b0, 1'b0, 3'b000, 32'h7654_3210, 32'h0, 5'd14, 1'b1, 3'd4, 0, 0, 32'h0);
        run_op(1'b0, 1'b0, 3'b000, 32'h0000_0001, 32'h0, 5'd15, 1'b0, 3'd5, 0, 0, 32'h0);
        // LHU never granted: timeout
        run_op(1'b1, 1'b0, 3'b101, 32'h2, 32'h0, 5'd16, 1'b1, 3'd2, -1, 0, 32'h0);
        chk("TO_rwe_pin", 32'(register_write_enable_out), 32'd0);
        // LW completing one cycle before the timeout
        run_op(1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 5'd17, 1'b1, 3'd2, 0, 253, 32'h0F0E_0D0C);

        // Reset while a load waits in RESP, then a stale rvalid
        step();
        valid_in = 1'b1; alu_out_in = 32'h104; funct3_in = 3'b000; instruction_rd_in = 5'd7;
        register_write_enable_in = 1'b1; mem_request_type_in = 1'b1;
        mem_request_write_in = 1'b0; wb_sel_in = 3'd2;
        exp_addr = 32'h104; exp_be = 4'hF; exp_we = 1'b0;
        exp_stall = 1'b0; exp_valid = 1'b0; exp_req = 1'b0;
        step();
        set_junk();
        bus.dmem_gnt = 1'b1; exp_stall = 1'b1; exp_req = 1'b1;
        step();
        bus.dmem_gnt = 1'b0; exp_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_stall = 1'b0;
        chk_all_zero("midrst");
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h1122_3344;
        step();
        bus.dmem_rvalid = 1'b0;
        step();
        // Recovery after reset
        run_op(1'b1, 1'b0, 3'b000, 32'h1FE, 32'h0, 5'd18, 1'b1, 3'd2, 0, 1, 32'h007F_0000);
        chk("recover_pin", load_data_out, 32'h0000_007F);
        step();
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
